// File: rtl/numarator_pkg.sv
// Shared constants and types for the numarator_mod up/down counter.
// Holds the wrap/saturate mode codes, default geometry and the step-decision encoding.
package numarator_pkg;

   localparam int MODE_WRAP = 0;
   localparam int MODE_SAT  = 1;

   localparam int     DEF_WIDTH   = 8;
   localparam longint DEF_MODULUS = 256;

   typedef enum logic [1:0] {
      OP_HOLD  = 2'd0,
      OP_INC   = 2'd1,
      OP_DEC   = 2'd2,
      OP_BOUND = 2'd3
   } step_op_t;

endpackage

// File: rtl/numarator_mod_tick_gen.sv
// Prescaler: emits one tick every PRESCALE enabled cycles and restarts on sync_clr.
// The count holds while en is low, so a pending step is only delayed and never lost.
module tick_gen #(
   parameter int PRESCALE = 1
) (
   input  logic CLK,
   input  logic RST_N,
   input  logic en,
   input  logic sync_clr,
   output logic tick
);

   localparam int PW = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;
   localparam logic [PW-1:0] LAST = PW'(PRESCALE - 1);

   logic [PW-1:0] cnt;

   assign tick = en && (cnt == LAST);

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         cnt <= '0;
      end else if (sync_clr) begin
         cnt <= '0;
      end else if (en) begin
         cnt <= tick ? '0 : cnt + PW'(1);
      end
   end

endmodule

// File: rtl/numarator_mod.sv
// Parametrised up/down counter with modulus, prescale, wrap/saturate mode,
// synchronous clear and clamped parallel load.
module numarator_mod
   import numarator_pkg::*;
#(
   parameter int     WIDTH    = DEF_WIDTH,
   parameter longint MODULUS  = DEF_MODULUS,
   parameter int     PRESCALE = 1,
   parameter int     SATURATE = MODE_WRAP
) (
   input  logic             CLK,
   input  logic             RST_N,
   input  logic             en,
   input  logic             up,
   input  logic             clr,
   input  logic             load,
   input  logic [WIDTH-1:0] d,
   output logic [WIDTH-1:0] q,
   output logic             tc,
   output logic             wrap
);

   localparam logic [WIDTH-1:0] MAXV = WIDTH'(MODULUS - 1);

   logic             tick;
   logic [WIDTH-1:0] d_clamped;
   logic [WIDTH-1:0] q_nxt;
   step_op_t         op;

   tick_gen #(
      .PRESCALE(PRESCALE)
   ) u_tick_gen (
      .CLK     (CLK),
      .RST_N   (RST_N),
      .en      (en),
      .sync_clr(clr | load),
      .tick    (tick)
   );

   assign d_clamped = (d > MAXV) ? MAXV : d;
   assign tc        = up ? (q == MAXV) : (q == '0);

   // Direction is sampled on the tick edge itself; between ticks it is ignored.
   always_comb begin
      op    = OP_HOLD;
      q_nxt = q;
      if (tick) begin
         if (up) begin
            op = (q == MAXV) ? OP_BOUND : OP_INC;
         end else begin
            op = (q == '0) ? OP_BOUND : OP_DEC;
         end
      end
      case (op)
         OP_INC:   q_nxt = q + WIDTH'(1);
         OP_DEC:   q_nxt = q - WIDTH'(1);
         OP_BOUND: begin
            if (SATURATE == MODE_SAT) begin
               q_nxt = q;
            end else begin
               q_nxt = up ? '0 : MAXV;
            end
         end
         default:  q_nxt = q;
      endcase
   end

   always_ff @(posedge CLK or negedge RST_N) begin
      if (!RST_N) begin
         q    <= '0;
         wrap <= 1'b0;
      end else if (clr) begin
         q    <= '0;
         wrap <= 1'b0;
      end else if (load) begin
         q    <= d_clamped;
         wrap <= 1'b0;
      end else begin
         q    <= q_nxt;
         wrap <= (op == OP_BOUND);
      end
   end

endmodule

// File: tb/tb_numarator_mod.sv
// Bench for numarator_mod: three configurations share one stimulus stream and are
// compared every cycle against a plain-arithmetic model of the counting rules.
module tb_numarator_mod;

   logic       CLK = 1'b0;
   logic       RST_N = 1'b0;
   logic       en = 1'b0;
   logic       up = 1'b1;
   logic       clr = 1'b0;
   logic       load = 1'b0;
   logic [7:0] d = '0;

   logic [7:0] qa;
   logic [3:0] qb, qc;
   logic       tca, tcb, tcc, wrapa, wrapb, wrapc;

   int total = 0;
   int bad   = 0;

   // Instance parameters mirrored for the model: A free 0..255, B mod-10 wrap, C mod-10 saturate prescale 4
   int modv[3] = '{256, 10, 10};
   int psv[3]  = '{1, 1, 4};
   int satv[3] = '{0, 0, 1};
   string nm[3] = '{"A", "B", "C"};

   int mq[3];
   int mpre[3];
   int mw[3];

   always #5 CLK = ~CLK;

   numarator_mod #(.WIDTH(8), .MODULUS(256), .PRESCALE(1), .SATURATE(0)) dut_a (
      .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .clr(clr), .load(load),
      .d(d), .q(qa), .tc(tca), .wrap(wrapa));

   numarator_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(1), .SATURATE(0)) dut_b (
      .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .clr(clr), .load(load),
      .d(d[3:0]), .q(qb), .tc(tcb), .wrap(wrapb));

   numarator_mod #(.WIDTH(4), .MODULUS(10), .PRESCALE(4), .SATURATE(1)) dut_c (
      .CLK(CLK), .RST_N(RST_N), .en(en), .up(up), .clr(clr), .load(load),
      .d(d[3:0]), .q(qc), .tc(tcc), .wrap(wrapc));

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      total++;
      assert (obs === exp)
      else begin
         bad++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] obs_q(input int k);
      case (k)
         0:       return 32'(qa);
         1:       return 32'(qb);
         default: return 32'(qc);
      endcase
   endfunction

   function automatic logic [31:0] obs_tc(input int k);
      case (k)
         0:       return 32'(tca);
         1:       return 32'(tcb);
         default: return 32'(tcc);
      endcase
   endfunction

   function automatic logic [31:0] obs_w(input int k);
      case (k)
         0:       return 32'(wrapa);
         1:       return 32'(wrapb);
         default: return 32'(wrapc);
      endcase
   endfunction

   task automatic model_reset();
      for (int k = 0; k < 3; k++) begin
         mq[k] = 0; mpre[k] = 0; mw[k] = 0;
      end
   endtask

   task automatic model_edge();
      for (int k = 0; k < 3; k++) begin
         int dv;
         bit tk;
         dv = (k == 0) ? int'(d) : int'(d[3:0]);
         if (!RST_N) begin
            mq[k] = 0; mpre[k] = 0; mw[k] = 0;
         end else if (clr) begin
            mq[k] = 0; mpre[k] = 0; mw[k] = 0;
         end else if (load) begin
            mq[k] = (dv >= modv[k]) ? modv[k] - 1 : dv;
            mpre[k] = 0; mw[k] = 0;
         end else begin
            mw[k] = 0;
            tk = 0;
            if (en) begin
               if (mpre[k] == psv[k] - 1) begin
                  mpre[k] = 0; tk = 1;
               end else begin
                  mpre[k]++;
               end
            end
            if (tk) begin
               if (up) begin
                  if (mq[k] == modv[k] - 1) begin
                     mw[k] = 1;
                     if (!satv[k]) mq[k] = 0;
                  end else mq[k]++;
               end else begin
                  if (mq[k] == 0) begin
                     mw[k] = 1;
                     if (!satv[k]) mq[k] = modv[k] - 1;
                  end else mq[k]--;
               end
            end
         end
      end
   endtask

   task automatic check_all();
      for (int k = 0; k < 3; k++) begin
         int etc;
         etc = up ? int'(mq[k] == modv[k] - 1) : int'(mq[k] == 0);
         chk({nm[k], "_q"},    obs_q(k),  32'(mq[k]));
         chk({nm[k], "_tc"},   obs_tc(k), 32'(etc));
         chk({nm[k], "_wrap"}, obs_w(k),  32'(mw[k]));
      end
   endtask

   task automatic step();
      @(posedge CLK);
      model_edge();
      #1;
      check_all();
   endtask

   // Pulse RST_N low between edges and check the outputs clear without waiting for a clock.
   task automatic areset();
      #2;
      RST_N = 1'b0;
      #1;
      model_reset();
      check_all();
      #1;
      RST_N = 1'b1;
   endtask

   initial begin
      model_reset();
      // Reset state
      step();
      step();
      chk("reset_qa", 32'(qa), 0);
      chk("reset_wrapa", 32'(wrapa), 0);
      RST_N = 1'b1;

      // Free run up from reset
      en = 1'b1; up = 1'b1;
      for (int i = 1; i <= 260; i++) begin
         step();
         if (i == 255) chk("A_tc_at_255", 32'(tca), 1);
         if (i == 256) begin
            chk("A_wrap_on_return", 32'(wrapa), 1);
            chk("A_q_return_0", 32'(qa), 0);
         end
      end

      // Modulo down from 0
      clr = 1'b1; step(); clr = 1'b0;
      up = 1'b0;
      step();
      chk("B_down_first_9", 32'(qb), 9);
      chk("B_down_wrap", 32'(wrapb), 1);
      for (int i = 0; i < 24; i++) step();

      // Clamped load then saturate
      load = 1'b1; d = 8'd12; step(); load = 1'b0;
      chk("C_load_clamp", 32'(qc), 9);
      chk("B_load_clamp", 32'(qb), 9);
      up = 1'b1;
      for (int i = 0; i < 12; i++) step();
      chk("C_sat_hold", 32'(qc), 9);
      up = 1'b0;
      for (int i = 0; i < 4; i++) step();
      chk("C_sat_down_8", 32'(qc), 8);

      // Prescale with en dropped mid-count
      up = 1'b1;
      clr = 1'b1; step(); clr = 1'b0;
      step(); step();
      en = 1'b0; step(); step(); step();
      en = 1'b1; step();
      chk("C_prescale_delayed", 32'(qc), 0);
      step();
      chk("C_prescale_step", 32'(qc), 1);

      // clr beats load; then async reset while q=7
      clr = 1'b1; load = 1'b1; d = 8'd5; step();
      chk("A_clr_over_load", 32'(qa), 0);
      clr = 1'b0; d = 8'd7; step(); load = 1'b0;
      chk("B_load_7", 32'(qb), 7);
      en = 1'b0;
      areset();
      chk("B_async_clear", 32'(qb), 0);
      en = 1'b1; up = 1'b1;
      step();
      chk("B_resume_1", 32'(qb), 1);

      // Randomised operation
      for (int i = 0; i < 3000; i++) begin
         en   = ($urandom_range(0, 99) < 70);
         up   = ($urandom_range(0, 99) < 55);
         clr  = ($urandom_range(0, 99) < 3);
         load = ($urandom_range(0, 99) < 5);
         d    = 8'($urandom);
         step();
         if ($urandom_range(0, 99) < 1) areset();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

   initial begin
      #1000000;
      $display("FAIL timeout observed=running expected=finished");
      $fatal(1, "bench timeout");
   end

endmodule
